refill_arbiter: RTL and testbench
=================================

Name: refill_arbiter

Overview:
- Shares a single refill memory port between two cache miss ports: port 0 (instruction cache) and port 1 (data cache).
- Each cache-side port uses the cache's rd_req/rd_addr/ret_valid/ret_data(128b line) protocol.
- Grants one miss at a time with round-robin priority, forwards the line address to memory, and routes the returned line back to the granted cache only.
- Includes a watchdog so a lost memory response cannot hang a cache.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, refill line width in bits.
- TIMEOUT, 255, max cycles in WAIT before abort. Must be >= 1 and fit in the 8-bit counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- c0_rd_req  in  1  port 0 (I-cache) refill request, level.
- c0_rd_addr  in  ADDR_W  port 0 line address.
- c0_ret_valid  out  1  port 0 line-return strobe, one cycle.
- c0_ret_data  out  LINE_W  port 0 returned line.
- c1_rd_req  in  1  port 1 (D-cache) refill request, level.
- c1_rd_addr  in  ADDR_W  port 1 line address.
- c1_ret_valid  out  1  port 1 line-return strobe, one cycle.
- c1_ret_data  out  LINE_W  port 1 returned line.
- mem_rd_req  out  1  memory read request.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_rdy  in  1  memory accepts request this cycle.
- mem_ret_valid  in  1  memory line-return strobe.
- mem_ret_data  in  LINE_W  memory returned line.
- busy  out  1  transfer in progress (state != IDLE).
- timeout_err  out  1  sticky, set on watchdog abort.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, addr/data registers 0, wd counter 0, timeout_err=0.
- Requester contract: hold rd_req=1 with stable rd_addr until its ret_valid pulse.
- States: IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - If any rd_req=1, grant: a single requester wins; if both, the port equal to rr_ptr wins.
  - Latch gnt_id and the winner's rd_addr; go to ISSUE next cycle.
  - mem_rd_req=0 in IDLE.
- ISSUE:
  - mem_rd_req=1, mem_rd_addr = latched address (registered, stable).
  - Stay until mem_rd_rdy=1; then go to WAIT and clear wd.
- WAIT:
  - mem_rd_req=0. wd increments each cycle.
  - mem_ret_valid=1: latch mem_ret_data, go to RETURN.
  - Else if wd == TIMEOUT: latch data=0, set timeout_err, go to RETURN.
  - mem_ret_valid on the same cycle as wd==TIMEOUT: the data wins; timeout_err is not set.
- RETURN:
  - c{gnt_id}_ret_valid=1 for exactly this one cycle, c{gnt_id}_ret_data = latched line.
  - rr_ptr <= ~gnt_id. Go to IDLE.
  - The other port's ret_valid stays 0 and its ret_data holds its last value.
- Latency (no contention, mem_rd_rdy tied 1, memory returns N cycles after accept):
  - rd_req rise -> mem_rd_req at +1 cycle.
  - ret_valid at accept + N + 1.
- After grant, the winner dropping rd_req does not abort; the transfer completes and ret_valid is still pulsed.
- A losing requester's rd_req is not latched; it is re-arbitrated in the next IDLE.
- mem_ret_valid outside WAIT is ignored (no data capture, no strobe).
- Minimum gap between transfers: one IDLE cycle; a held rd_req is granted on that cycle.
- Reset mid-transfer returns to IDLE immediately and drops the in-flight transfer; no ret_valid is generated.
- timeout_err clears only on reset.

Test Plan:
- Single I-miss:
  - Stimulus: c0_rd_req=1, c0_rd_addr=32'hDEBAD000, mem_rd_rdy=1, mem returns 128'h34567891_02345678_91023456_78910234 7 cycles after accept.
  - Required: mem_rd_addr=32'hDEBAD000; c0_ret_valid one cycle with that data; c1_ret_valid never high.
- Simultaneous requests after reset:
  - Stimulus: c0 addr 32'h1000, c1 addr 32'h2000, both rd_req=1, rr_ptr=0.
  - Required: port 0 served first, then port 1 (mem_rd_addr 1000 then 2000); each port gets exactly one ret_valid.
- Round-robin fairness:
  - Stimulus: both ports request continuously for 4 transfers.
  - Required: grant order 0,1,0,1.
- Backpressure:
  - Stimulus: mem_rd_rdy held 0 for 5 cycles.
  - Required: mem_rd_req=1 with stable address for all 5 cycles, plus the accept cycle; busy=1 throughout.
- Watchdog:
  - Stimulus: TIMEOUT=8, memory never returns.
  - Required: c1_ret_valid pulses with data 0 after 9 WAIT cycles; timeout_err=1 and stays high; a following request still completes normally.
- Reset mid-WAIT:
  - Stimulus: rst=0 pulse during WAIT.
  - Required: immediately busy=0 and mem_rd_req=0; no ret_valid on either port; a later mem_ret_valid is ignored.

Source files
------------

// File: rtl/refill_arbiter_if.sv
// Refill bus bundle: two cache miss ports (I-cache = c0, D-cache = c1)
// plus the shared memory read port. The arbiter uses the slave view. The
// environment (caches and memory model) uses the master view.
interface refill_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    // Cache port 0 (instruction cache)
    logic              c0_rd_req;
    logic [ADDR_W-1:0] c0_rd_addr;
    logic              c0_ret_valid;
    logic [LINE_W-1:0] c0_ret_data;

    // Cache port 1 (data cache)
    logic              c1_rd_req;
    logic [ADDR_W-1:0] c1_rd_addr;
    logic              c1_ret_valid;
    logic [LINE_W-1:0] c1_ret_data;

    // Shared memory read port
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_rdy;
    logic              mem_ret_valid;
    logic [LINE_W-1:0] mem_ret_data;

    modport slave (
        input  c0_rd_req, c0_rd_addr, c1_rd_req, c1_rd_addr,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_data,
        output c0_ret_valid, c0_ret_data, c1_ret_valid, c1_ret_data,
        output mem_rd_req, mem_rd_addr
    );

    modport master (
        output c0_rd_req, c0_rd_addr, c1_rd_req, c1_rd_addr,
        output mem_rd_rdy, mem_ret_valid, mem_ret_data,
        input  c0_ret_valid, c0_ret_data, c1_ret_valid, c1_ret_data,
        input  mem_rd_req, mem_rd_addr
    );
endinterface

// File: rtl/refill_arbiter.sv
// Refill arbiter: shares one memory read port between the I-cache (port 0)
// and the D-cache (port 1). One miss is in flight at a time. When both
// ports request together, rr_ptr picks the winner, and rr_ptr then points
// at the loser after each transfer. A watchdog turns a lost memory response
// into a zero line plus a sticky error flag, so that no cache can hang.
module refill_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255     // 1..255, compared against an 8-bit counter
) (
    input  logic                  clk,
    input  logic                  rst,          // async, active-low
    refill_arbiter_if.slave       bus,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wd_q, wd_d;
    logic              timeout_err_q, timeout_err_d;
    logic              c0_ret_valid_q, c0_ret_valid_d;
    logic              c1_ret_valid_q, c1_ret_valid_d;
    logic [LINE_W-1:0] c0_ret_data_q, c0_ret_data_d;
    logic [LINE_W-1:0] c1_ret_data_q, c1_ret_data_d;

    // Arbitration and leave-WAIT scratch values
    logic              win_id;
    logic              finish;
    logic [LINE_W-1:0] line_sel;

    // Next-state logic. Return strobes and lines are loaded on the
    // WAIT->RETURN edge, so they are register outputs during RETURN.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_id_d       = gnt_id_q;
        addr_d         = addr_q;
        wd_d           = wd_q;
        timeout_err_d  = timeout_err_q;
        c0_ret_valid_d = 1'b0;
        c1_ret_valid_d = 1'b0;
        c0_ret_data_d  = c0_ret_data_q;
        c1_ret_data_d  = c1_ret_data_q;
        win_id         = 1'b0;
        finish         = 1'b0;
        line_sel       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.c0_rd_req || bus.c1_rd_req) begin
                    // A single requester wins outright. On a tie, rr_ptr decides.
                    win_id   = (bus.c0_rd_req && bus.c1_rd_req) ? rr_ptr_q : bus.c1_rd_req;
                    gnt_id_d = win_id;
                    addr_d   = win_id ? bus.c1_rd_addr : bus.c0_rd_addr;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (bus.mem_rd_rdy) begin
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Real data beats the watchdog on the same cycle.
                if (bus.mem_ret_valid) begin
                    line_sel = bus.mem_ret_data;
                    finish   = 1'b1;
                end else if (wd_q == TIMEOUT_CNT) begin
                    line_sel      = '0;
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end

                if (finish) begin
                    state_d = ST_RETURN;
                    if (gnt_id_q) begin
                        c1_ret_valid_d = 1'b1;
                        c1_ret_data_d  = line_sel;
                    end else begin
                        c0_ret_valid_d = 1'b1;
                        c0_ret_data_d  = line_sel;
                    end
                end
            end

            ST_RETURN: begin
                rr_ptr_d = ~gnt_id_q;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register. Reset drops any in-flight transfer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= 1'b0;
            gnt_id_q       <= 1'b0;
            addr_q         <= '0;
            wd_q           <= '0;
            timeout_err_q  <= 1'b0;
            c0_ret_valid_q <= 1'b0;
            c1_ret_valid_q <= 1'b0;
            c0_ret_data_q  <= '0;
            c1_ret_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_id_q       <= gnt_id_d;
            addr_q         <= addr_d;
            wd_q           <= wd_d;
            timeout_err_q  <= timeout_err_d;
            c0_ret_valid_q <= c0_ret_valid_d;
            c1_ret_valid_q <= c1_ret_valid_d;
            c0_ret_data_q  <= c0_ret_data_d;
            c1_ret_data_q  <= c1_ret_data_d;
        end
    end

    // Output decode. All outputs are functions of registered state only.
    assign bus.mem_rd_req   = (state_q == ST_ISSUE);
    assign bus.mem_rd_addr  = addr_q;
    assign bus.c0_ret_valid = c0_ret_valid_q;
    assign bus.c0_ret_data  = c0_ret_data_q;
    assign bus.c1_ret_valid = c1_ret_valid_q;
    assign bus.c1_ret_data  = c1_ret_data_q;
    assign busy             = (state_q != ST_IDLE);
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter. The bench drives both caches and the
// memory by hand. A negedge monitor logs and counts every return strobe.
module tb_refill_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic busy;
    logic timeout_err;

    refill_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    refill_arbiter #(
        .ADDR_W (32),
        .LINE_W (128),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int c0_cnt   = 0;
    int c1_cnt   = 0;

    localparam logic [127:0] D_I  = 128'h34567891_02345678_91023456_78910234;
    localparam logic [127:0] D_A  = 128'hAAAA0000_11112222_33334444_55556666;
    localparam logic [127:0] D_B  = 128'hBBBB0000_77778888_9999AAAA_BBBBCCCC;
    localparam logic [127:0] D_T  = 128'hCAFEF00D_00000000_12345678_9ABCDEF0;
    localparam logic [127:0] D_N  = 128'h0F0F0F0F_F0F0F0F0_01020304_05060708;
    localparam logic [127:0] D_X  = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;

    // Return-strobe monitor: one line per completed transaction
    always @(negedge clk) begin
        if (bus.c0_ret_valid) begin
            c0_cnt++;
            $display("txn port=0 data=%h t=%0t", bus.c0_ret_data, $time);
        end
        if (bus.c1_ret_valid) begin
            c1_cnt++;
            $display("txn port=1 data=%h t=%0t", bus.c1_ret_data, $time);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One transfer from IDLE. mem_rd_rdy must be 1 and the requests must
    // already be set up. Memory answers n cycles after accept (n >= 1), so
    // the strobe must appear at accept + n + 1. The task ends in the IDLE
    // cycle that follows.
    task automatic do_txn(input logic [127:0] data, input int n,
                          input int port, input logic [31:0] addr);
        tick;   // grant edge -> ISSUE (this is also the accept cycle)
        check_b("issue_req", bus.mem_rd_req, 1'b1);
        check_v("issue_addr", 128'(bus.mem_rd_addr), 128'(addr));
        tick;   // accept edge -> WAIT, first cycle after accept
        check_b("wait_req_low", bus.mem_rd_req, 1'b0);
        repeat (n - 1) tick;
        bus.mem_ret_valid = 1'b1;
        bus.mem_ret_data  = data;
        tick;   // RETURN
        bus.mem_ret_valid = 1'b0;
        bus.mem_ret_data  = '0;
        if (port == 0) begin
            check_b("c0_ret_valid", bus.c0_ret_valid, 1'b1);
            check_v("c0_ret_data", bus.c0_ret_data, data);
            check_b("c1_ret_quiet", bus.c1_ret_valid, 1'b0);
        end else begin
            check_b("c1_ret_valid", bus.c1_ret_valid, 1'b1);
            check_v("c1_ret_data", bus.c1_ret_data, data);
            check_b("c0_ret_quiet", bus.c0_ret_valid, 1'b0);
        end
        tick;   // IDLE
        check_b("idle_busy", busy, 1'b0);
        check_b("pulse_end", (port == 0) ? bus.c0_ret_valid : bus.c1_ret_valid, 1'b0);
    endtask

    initial begin
        rst               = 1'b0;
        bus.c0_rd_req     = 1'b0;
        bus.c0_rd_addr    = '0;
        bus.c1_rd_req     = 1'b0;
        bus.c1_rd_addr    = '0;
        bus.mem_rd_rdy    = 1'b0;
        bus.mem_ret_valid = 1'b0;
        bus.mem_ret_data  = '0;
        tick;
        tick;

        // ---- Reset state
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_mem_req", bus.mem_rd_req, 1'b0);
        check_v("rst_mem_addr", 128'(bus.mem_rd_addr), 128'h0);
        check_b("rst_c0_valid", bus.c0_ret_valid, 1'b0);
        check_b("rst_c1_valid", bus.c1_ret_valid, 1'b0);
        check_v("rst_c0_data", bus.c0_ret_data, 128'h0);
        check_b("rst_timeout", timeout_err, 1'b0);
        rst = 1'b1;
        tick;

        // ---- Single I-miss, memory answers 7 cycles after accept
        bus.mem_rd_rdy = 1'b1;
        bus.c0_rd_req  = 1'b1;
        bus.c0_rd_addr = 32'hDEBAD000;
        do_txn(D_I, 7, 0, 32'hDEBAD000);
        bus.c0_rd_req = 1'b0;
        tick;
        check_i("imiss_c0_cnt", c0_cnt, 1);
        check_i("imiss_c1_cnt", c1_cnt, 0);
        check_v("imiss_data_held", bus.c0_ret_data, D_I);

        // ---- Simultaneous requests right after reset (rr_ptr = 0)
        rst = 1'b0;
        tick;
        rst = 1'b1;
        bus.c0_rd_req  = 1'b1;
        bus.c0_rd_addr = 32'h1000;
        bus.c1_rd_req  = 1'b1;
        bus.c1_rd_addr = 32'h2000;
        do_txn(D_A, 3, 0, 32'h1000);
        bus.c0_rd_req = 1'b0;
        do_txn(D_B, 3, 1, 32'h2000);
        bus.c1_rd_req = 1'b0;
        tick;
        check_i("simul_c0_cnt", c0_cnt, 2);
        check_i("simul_c1_cnt", c1_cnt, 1);
        check_v("simul_c0_held", bus.c0_ret_data, D_A);

        // ---- Round robin: both ports request continuously, order 0,1,0,1
        bus.c0_rd_req  = 1'b1;
        bus.c0_rd_addr = 32'h1100;
        bus.c1_rd_req  = 1'b1;
        bus.c1_rd_addr = 32'h2200;
        do_txn(D_A, 2, 0, 32'h1100);
        do_txn(D_B, 2, 1, 32'h2200);
        do_txn(D_B, 1, 0, 32'h1100);
        do_txn(D_A, 1, 1, 32'h2200);
        bus.c0_rd_req = 1'b0;
        bus.c1_rd_req = 1'b0;
        tick;
        check_i("rr_c0_cnt", c0_cnt, 4);
        check_i("rr_c1_cnt", c1_cnt, 3);

        // ---- Backpressure: mem_rd_rdy low for 5 ISSUE cycles
        bus.mem_rd_rdy = 1'b0;
        bus.c1_rd_req  = 1'b1;
        bus.c1_rd_addr = 32'h3000;
        tick;
        for (int i = 0; i < 5; i++) begin
            check_b("bp_req", bus.mem_rd_req, 1'b1);
            check_v("bp_addr", 128'(bus.mem_rd_addr), 128'h3000);
            check_b("bp_busy", busy, 1'b1);
            tick;
        end
        bus.mem_rd_rdy = 1'b1;
        check_b("bp_accept_req", bus.mem_rd_req, 1'b1);
        check_v("bp_accept_addr", 128'(bus.mem_rd_addr), 128'h3000);
        tick;
        check_b("bp_wait_req", bus.mem_rd_req, 1'b0);
        check_b("bp_wait_busy", busy, 1'b1);
        bus.mem_ret_valid = 1'b1;
        bus.mem_ret_data  = D_N;
        tick;
        bus.mem_ret_valid = 1'b0;
        check_b("bp_c1_valid", bus.c1_ret_valid, 1'b1);
        check_v("bp_c1_data", bus.c1_ret_data, D_N);
        bus.c1_rd_req = 1'b0;
        tick;

        // ---- Data arriving on the watchdog's last cycle wins
        bus.c1_rd_req  = 1'b1;
        bus.c1_rd_addr = 32'h6000;
        do_txn(D_T, 9, 1, 32'h6000);
        bus.c1_rd_req = 1'b0;
        check_b("edge_no_timeout", timeout_err, 1'b0);
        tick;

        // ---- Watchdog: memory never answers, TIMEOUT = 8
        bus.c1_rd_req  = 1'b1;
        bus.c1_rd_addr = 32'h4000;
        tick;
        check_b("wd_issue", bus.mem_rd_req, 1'b1);
        tick;
        for (int k = 1; k <= 9; k++) begin
            check_b("wd_quiet", bus.c1_ret_valid, 1'b0);
            check_b("wd_busy", busy, 1'b1);
            tick;
        end
        check_b("wd_c1_valid", bus.c1_ret_valid, 1'b1);
        check_v("wd_c1_data", bus.c1_ret_data, 128'h0);
        check_b("wd_err_set", timeout_err, 1'b1);
        check_b("wd_c0_quiet", bus.c0_ret_valid, 1'b0);
        bus.c1_rd_req = 1'b0;
        tick;
        check_b("wd_err_sticky", timeout_err, 1'b1);
        bus.c0_rd_req  = 1'b1;
        bus.c0_rd_addr = 32'h5000;
        do_txn(D_N, 2, 0, 32'h5000);
        bus.c0_rd_req = 1'b0;
        check_b("wd_err_still", timeout_err, 1'b1);
        tick;

        // ---- Reset mid-WAIT, then a late memory strobe must be ignored
        bus.c0_rd_req  = 1'b1;
        bus.c0_rd_addr = 32'h7000;
        tick;
        tick;
        tick;
        check_b("mid_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_b("mid_busy", busy, 1'b0);
        check_b("mid_mem_req", bus.mem_rd_req, 1'b0);
        check_b("mid_err_clr", timeout_err, 1'b0);
        bus.c0_rd_req = 1'b0;
        tick;
        rst = 1'b1;
        begin
            int c0_snap;
            int c1_snap;
            c0_snap = c0_cnt;
            c1_snap = c1_cnt;
            bus.mem_ret_valid = 1'b1;
            bus.mem_ret_data  = D_X;
            tick;
            bus.mem_ret_valid = 1'b0;
            bus.mem_ret_data  = '0;
            tick;
            tick;
            check_b("late_busy", busy, 1'b0);
            check_i("late_c0_cnt", c0_cnt, c0_snap);
            check_i("late_c1_cnt", c1_cnt, c1_snap);
            check_v("late_c0_data", bus.c0_ret_data, 128'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
